// File: rtl/q_cnot_seq.sv
// q_cnot_seq: time-multiplexed two-qubit gate engine (tensor product / CNOT).
// One shared complex multiplier (four q_mul, two q_add) produces one joint
// amplitude per cycle over four CALC cycles.
// Optional feature: define Q_SEQ_PERF_EN to add the op_count completion counter.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef FIXED_FRAC
`define FIXED_FRAC 8
`endif

module q_cnot_seq #(
  parameter int unsigned OP_CNT_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           gate_sel,
  input  logic signed [`FIXED_WIDTH-1:0] control_real_0,
  input  logic signed [`FIXED_WIDTH-1:0] control_imag_0,
  input  logic signed [`FIXED_WIDTH-1:0] control_real_1,
  input  logic signed [`FIXED_WIDTH-1:0] control_imag_1,
  input  logic signed [`FIXED_WIDTH-1:0] target_real_0,
  input  logic signed [`FIXED_WIDTH-1:0] target_imag_0,
  input  logic signed [`FIXED_WIDTH-1:0] target_real_1,
  input  logic signed [`FIXED_WIDTH-1:0] target_imag_1,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [`FIXED_WIDTH-1:0] out_real_00,
  output logic signed [`FIXED_WIDTH-1:0] out_imag_00,
  output logic signed [`FIXED_WIDTH-1:0] out_real_01,
  output logic signed [`FIXED_WIDTH-1:0] out_imag_01,
  output logic signed [`FIXED_WIDTH-1:0] out_real_10,
  output logic signed [`FIXED_WIDTH-1:0] out_imag_10,
  output logic signed [`FIXED_WIDTH-1:0] out_real_11,
  output logic signed [`FIXED_WIDTH-1:0] out_imag_11,
  output logic                           busy
`ifdef Q_SEQ_PERF_EN
  ,
  output logic [OP_CNT_W-1:0]            op_count
`endif
);

  localparam int unsigned W = `FIXED_WIDTH;
  localparam int unsigned F = `FIXED_FRAC;

  typedef logic signed [W-1:0] fx_t;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fixed-point multiply: full-width product, arithmetic shift, truncate (wraps).
  function automatic fx_t q_mul(input fx_t a, input fx_t b);
    logic signed [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return W'(p >>> F);
  endfunction

  // Fixed-point add with two's-complement wrap.
  function automatic fx_t q_add(input fx_t a, input fx_t b);
    return W'(a + b);
  endfunction

  state_t     state_q;
  logic [1:0] idx_q;
  logic       gate_sel_q;
  cplx_t      ctl0_q, ctl1_q, tgt0_q, tgt1_q;

  cplx_t      mul_a, mul_b;
  fx_t        p_ac, p_bd, p_ad, p_bc;
  cplx_t      prod_d;

  // Select the operand pair for the current slot; gate_sel swaps the target for control=1.
  always_comb begin
    mul_a = ctl0_q;
    mul_b = tgt0_q;
    case (idx_q)
      2'd0: begin
        mul_a = ctl0_q;
        mul_b = tgt0_q;
      end
      2'd1: begin
        mul_a = ctl0_q;
        mul_b = tgt1_q;
      end
      2'd2: begin
        mul_a = ctl1_q;
        mul_b = gate_sel_q ? tgt1_q : tgt0_q;
      end
      default: begin
        mul_a = ctl1_q;
        mul_b = gate_sel_q ? tgt0_q : tgt1_q;
      end
    endcase
  end

  // Shared complex multiplier: (a+bi)(c+di).
  assign p_ac      = q_mul(mul_a.re, mul_b.re);
  assign p_bd      = q_mul(mul_a.im, mul_b.im);
  assign p_ad      = q_mul(mul_a.re, mul_b.im);
  assign p_bc      = q_mul(mul_a.im, mul_b.re);
  assign prod_d.re = q_add(p_ac, -p_bd);
  assign prod_d.im = q_add(p_ad, p_bc);

  // Sequencer FSM with registered handshake, status and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      gate_sel_q  <= 1'b0;
      ctl0_q      <= '0;
      ctl1_q      <= '0;
      tgt0_q      <= '0;
      tgt1_q      <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_real_00 <= '0;
      out_imag_00 <= '0;
      out_real_01 <= '0;
      out_imag_01 <= '0;
      out_real_10 <= '0;
      out_imag_10 <= '0;
      out_real_11 <= '0;
      out_imag_11 <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            ctl0_q     <= '{re: control_real_0, im: control_imag_0};
            ctl1_q     <= '{re: control_real_1, im: control_imag_1};
            tgt0_q     <= '{re: target_real_0,  im: target_imag_0};
            tgt1_q     <= '{re: target_real_1,  im: target_imag_1};
            gate_sel_q <= gate_sel;
            idx_q      <= 2'd0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state_q    <= ST_CALC;
          end
        end
        ST_CALC: begin
          case (idx_q)
            2'd0: begin
              out_real_00 <= prod_d.re;
              out_imag_00 <= prod_d.im;
            end
            2'd1: begin
              out_real_01 <= prod_d.re;
              out_imag_01 <= prod_d.im;
            end
            2'd2: begin
              out_real_10 <= prod_d.re;
              out_imag_10 <= prod_d.im;
            end
            default: begin
              out_real_11 <= prod_d.re;
              out_imag_11 <= prod_d.im;
            end
          endcase
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            out_valid <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef Q_SEQ_PERF_EN
  // Completed-operation counter, wraps naturally at 2^OP_CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + OP_CNT_W'(1);
    end
  end
`else
  logic unused_op_cnt_w;
  assign unused_op_cnt_w = ^OP_CNT_W;
`endif

endmodule

// File: doc/q_cnot_seq.md
Name: q_cnot_seq

Overview:
- Time-multiplexed two-qubit gate engine that uses one shared complex multiplier.
- Takes two single-qubit states: control (c0, c1) and target (t0, t1). Each amplitude is a complex `FIXED_WIDTH fixed-point value.
- Produces the four-amplitude joint state, with an optional CNOT permutation applied.
- Replaces the fully parallel 16-multiplier gate with 4 q_mul and 2 q_add instances, sequenced over 4 cycles.
- Sits between the state-preparation stage and the measurement stage. Uses valid/ready handshakes on both sides.

Parameters:
- OP_CNT_W, 32, width of the optional completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- gate_sel  in  1  0 = plain tensor product; 1 = CNOT.
- control_real_0 / control_imag_0 / control_real_1 / control_imag_1  in  `FIXED_WIDTH each, signed  control amplitudes.
- target_real_0 / target_imag_0 / target_real_1 / target_imag_1  in  `FIXED_WIDTH each, signed  target amplitudes.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_real_00 / out_imag_00 … out_real_11 / out_imag_11  out  `FIXED_WIDTH each, signed  registered result amplitudes.
- busy  out  1  high in CALC or DONE.
- op_count  out  OP_CNT_W  present only with Q_SEQ_PERF_EN.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, idx=0.
  - All out_* amplitude registers are 0; out_valid=0; busy=0.
  - in_ready=1 from the first cycle after reset.
  - Any captured operands are discarded, including when reset hits mid-CALC or in DONE.
- States and transitions:
  - IDLE: in_ready=1. Accept when in_valid && in_ready at an edge: register all 8 operands and gate_sel, set idx=0, go to CALC.
  - CALC: in_ready=0, busy=1. Each cycle the shared complex multiplier forms a product from the registered operands. On the edge the result is written to the slot selected by idx, and idx increments.
  - DONE: out_valid=1, busy=1, in_ready=0. All out_* are stable while out_valid=1. On out_valid && out_ready at an edge: out_valid→0, go to IDLE.
- Products per idx:
  - idx0: c0·t0 → slot 00.
  - idx1: c0·t1 → slot 01.
  - idx2: c1·t1 if gate_sel=1, else c1·t0 → slot 10.
  - idx3: c1·t0 if gate_sel=1, else c1·t1 → slot 11.
  - On the edge that writes idx3: go to DONE.
- Complex product (a+bi)(c+di):
  - real = q_mul(a,c) + q_add of −q_mul(b,d).
  - imag = q_mul(a,d) + q_mul(b,c).
  - Width, truncation and overflow wrap behaviour are exactly those of q_mul/q_add. No added saturation.
- Latency and throughput:
  - out_valid rises at the 4th rising edge after the accepting edge.
  - Minimum initiation interval is 6 cycles (accept, 4×CALC, 1 DONE cycle with out_ready=1), returning to IDLE.
  - in_valid in CALC/DONE is ignored. Upstream holds its data until in_ready.
- Output retention: out_* keep the last result after the handshake until the next write in CALC. No clearing on IDLE entry.
- Input changes after acceptance have no effect on the result in flight.
- out_ready held low: the block remains in DONE indefinitely, with no drop and no overwrite.
- gate_sel sampled only at acceptance.

Optional Feature:
- Macro: Q_SEQ_PERF_EN.
- Defined:
  - Port op_count exists.
  - Reset to 0 by rst.
  - Increments by 1 on each out_valid && out_ready edge; wraps to 0 after 2^OP_CNT_W−1.
- Undefined: port op_count and its register are absent. All other behaviour is identical.

Test Plan:
- Notation: ONE = fixed-point 1.0; rst released.
- Case 1: c1=ONE, t0=ONE (others 0), gate_sel=1, out_ready=1 → out_real_11=ONE, all other out_*=0; out_valid rises 4 edges after accept.
- Case 2: same operands, gate_sel=0 → out_real_10=ONE, all others 0.
- Case 3: control_imag_0=ONE, target_imag_0=ONE, gate_sel=0 → out_real_00=−ONE, out_imag_00=0.
- Case 4: out_ready=0 for 10 cycles after out_valid → out_* and out_valid constant, in_ready=0, busy=1. Raising out_ready gives a single handshake, then in_ready=1 next cycle.
- Case 5: rst asserted on 2nd CALC cycle → next cycle state IDLE, out_*=0, out_valid=0, in_ready=1. A following operation completes correctly.
- Case 6: back-to-back ops with in_valid held high and out_ready=1, 3 operations → initiation interval is 6 cycles. With Q_SEQ_PERF_EN, op_count=3. With OP_CNT_W=2 and 4 ops, op_count wraps to 0.
